// File: rtl/output_display.sv
// Display back-end for the CPU accumulator: iterative double-dabble binary-to-BCD
// conversion feeding a 4-digit multiplexed, active-low 7-segment display.
module output_display #(
  parameter int unsigned SCAN_DIV = 16,
  parameter bit          SIGNED   = 1'b0
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [7:0]  Value,
  input  logic        Halt,
  output logic [6:0]  Seg,
  output logic [3:0]  An,
  output logic        Busy,
  output logic [11:0] Bcd
);

  localparam int unsigned PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_H     = 7'b0001001;

  typedef enum logic {IDLE, CONV} state_t;

  state_t        state;
  logic [7:0]    shown_value;
  logic [7:0]    pend_value;
  logic [7:0]    mag;
  logic [11:0]   acc;
  logic [2:0]    step;
  logic          conv_neg;
  logic          shown_neg;
  logic          halt_r;
  logic [PW-1:0] prescale;
  logic [1:0]    idx;

  logic          value_neg;
  logic [7:0]    value_mag;
  logic [11:0]   acc_adj;
  logic [19:0]   shifted;
  logic [1:0]    next_idx;
  logic [6:0]    digit_seg;

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return SEG_BLANK;
    endcase
  endfunction

  always_comb begin
    value_neg = SIGNED && Value[7];
    value_mag = value_neg ? (8'd0 - Value) : Value;
  end

  // One double-dabble step: add-3 correction on every nibble, then shift left.
  always_comb begin
    acc_adj = acc;
    for (int unsigned i = 0; i < 3; i++) begin
      if (acc[i*4 +: 4] >= 4'd5)
        acc_adj[i*4 +: 4] = acc[i*4 +: 4] + 4'd3;
    end
    shifted = {acc_adj, mag} << 1;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state       <= IDLE;
      Busy        <= 1'b0;
      Bcd         <= '0;
      shown_value <= '0;
      shown_neg   <= 1'b0;
      pend_value  <= '0;
      conv_neg    <= 1'b0;
      mag         <= '0;
      acc         <= '0;
      step        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (Value != shown_value) begin
            pend_value <= Value;
            mag        <= value_mag;
            conv_neg   <= value_neg;
            acc        <= '0;
            step       <= '0;
            Busy       <= 1'b1;
            state      <= CONV;
          end
        end
        CONV: begin
          acc  <= shifted[19:8];
          mag  <= shifted[7:0];
          step <= step + 3'd1;
          if (step == 3'd7) begin
            Bcd         <= shifted[19:8];
            shown_value <= pend_value;
            shown_neg   <= conv_neg;
            Busy        <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Segment content for the digit about to be enabled; only latched results are shown.
  always_comb begin
    next_idx = idx + 2'd1;
    case (next_idx)
      2'd0:    digit_seg = seg_code(Bcd[3:0]);
      2'd1:    digit_seg = (Bcd[11:4] == 8'd0) ? SEG_BLANK : seg_code(Bcd[7:4]);
      2'd2:    digit_seg = (Bcd[11:8] == 4'd0) ? SEG_BLANK : seg_code(Bcd[11:8]);
      default: digit_seg = halt_r ? SEG_H : (shown_neg ? SEG_DASH : SEG_BLANK);
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      prescale <= '0;
      idx      <= '0;
      halt_r   <= 1'b0;
      An       <= 4'b1110;
      Seg      <= 7'b1000000;
    end else begin
      halt_r <= Halt;
      if (prescale == PW'(SCAN_DIV - 1)) begin
        prescale <= '0;
        idx      <= next_idx;
        An       <= ~(4'b0001 << next_idx);
        Seg      <= digit_seg;
      end else begin
        prescale <= prescale + PW'(1);
      end
    end
  end

endmodule

// File: tb/tb_output_display.sv
// Bench for output_display: unsigned and signed instances share stimulus and are
// checked every cycle against an arithmetic reference model, plus directed cases.
module tb_output_display;

  localparam int unsigned DIV = 4;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [7:0]  Value;
  logic        Halt;

  logic [6:0]  u_seg, s_seg;
  logic [3:0]  u_an, s_an;
  logic        u_busy, s_busy;
  logic [11:0] u_bcd, s_bcd;

  int n_tests = 0;
  int n_fail  = 0;

  output_display #(.SCAN_DIV(DIV), .SIGNED(1'b0)) u_dut (
    .Clock(Clock), .Reset(Reset), .Value(Value), .Halt(Halt),
    .Seg(u_seg), .An(u_an), .Busy(u_busy), .Bcd(u_bcd)
  );

  output_display #(.SCAN_DIV(DIV), .SIGNED(1'b1)) s_dut (
    .Clock(Clock), .Reset(Reset), .Value(Value), .Halt(Halt),
    .Seg(s_seg), .An(s_an), .Busy(s_busy), .Bcd(s_bcd)
  );

  always #5 Clock = ~Clock;

  logic [6:0] segtab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                              7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  // Reference model state; index 0 = unsigned instance, 1 = signed instance.
  int         m_cnt   [2];
  int         m_mag   [2];
  int         m_pmag  [2];
  bit         m_neg   [2];
  bit         m_pneg  [2];
  logic [7:0] m_raw   [2];
  logic [7:0] m_pend  [2];
  logic [11:0] m_bcd  [2];
  logic [6:0] exp_seg [2];
  logic [3:0] exp_an;
  int         m_pres, m_idx;
  bit         m_hr;

  function automatic logic [11:0] to_bcd(input int m);
    return 12'(((m / 100) << 8) | (((m / 10) % 10) << 4) | (m % 10));
  endfunction

  function automatic int mag_of(input logic [7:0] v, input bit sgn);
    if (sgn && v[7]) return 256 - int'(v);
    return int'(v);
  endfunction

  function automatic logic [6:0] model_digit(input int inst, input int d);
    int m;
    m = m_mag[inst];
    case (d)
      0:       return segtab[m % 10];
      1:       return (m < 10)  ? 7'b1111111 : segtab[(m / 10) % 10];
      2:       return (m < 100) ? 7'b1111111 : segtab[m / 100];
      default: return m_hr ? 7'b0001001 : (m_neg[inst] ? 7'b0111111 : 7'b1111111);
    endcase
  endfunction

  task automatic model_edge(input bit rst, input logic [7:0] v, input bit h);
    logic [3:0] t;
    if (rst) begin
      m_pres = 0; m_idx = 0; m_hr = 1'b0; exp_an = 4'b1110;
      for (int i = 0; i < 2; i++) begin
        m_cnt[i] = 0; m_mag[i] = 0; m_neg[i] = 1'b0; m_raw[i] = 8'd0;
        m_bcd[i] = 12'h000; exp_seg[i] = 7'b1000000;
      end
    end else begin
      if (m_pres == int'(DIV) - 1) begin
        m_pres = 0;
        m_idx  = (m_idx + 1) % 4;
        t = 4'b1111;
        t[m_idx] = 1'b0;
        exp_an = t;
        for (int i = 0; i < 2; i++) exp_seg[i] = model_digit(i, m_idx);
      end else begin
        m_pres++;
      end
      m_hr = h;
      for (int i = 0; i < 2; i++) begin
        if (m_cnt[i] > 0) begin
          m_cnt[i]--;
          if (m_cnt[i] == 0) begin
            m_raw[i] = m_pend[i];
            m_mag[i] = m_pmag[i];
            m_neg[i] = m_pneg[i];
            m_bcd[i] = to_bcd(m_pmag[i]);
          end
        end else if (v != m_raw[i]) begin
          m_pend[i] = v;
          m_pmag[i] = mag_of(v, i == 1);
          m_pneg[i] = (i == 1) && v[7];
          m_cnt[i]  = 8;
        end
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  task automatic check_all();
    check("u_busy", 32'(u_busy), 32'(m_cnt[0] > 0));
    check("u_bcd",  32'(u_bcd),  32'(m_bcd[0]));
    check("u_an",   32'(u_an),   32'(exp_an));
    check("u_seg",  32'(u_seg),  32'(exp_seg[0]));
    check("s_busy", 32'(s_busy), 32'(m_cnt[1] > 0));
    check("s_bcd",  32'(s_bcd),  32'(m_bcd[1]));
    check("s_an",   32'(s_an),   32'(exp_an));
    check("s_seg",  32'(s_seg),  32'(exp_seg[1]));
  endtask

  task automatic tick();
    bit r, h;
    logic [7:0] v;
    r = Reset; h = Halt; v = Value;
    @(posedge Clock);
    model_edge(r, v, h);
    #1;
    check_all();
  endtask

  task automatic wait_idle();
    int n;
    tick();
    n = 0;
    while ((u_busy || s_busy) && n < 20) begin
      tick();
      n++;
    end
    check("idle_timeout", 32'(n < 20), 32'd1);
  endtask

  task automatic wait_sign_digit();
    int n;
    n = 0;
    while (s_an != 4'b0111 && n < 40) begin
      tick();
      n++;
    end
    check("scan_timeout", 32'(n < 40), 32'd1);
  endtask

  typedef struct {
    logic [7:0]  v;
    bit          h;
    logic [11:0] bcd_u;
    logic [11:0] bcd_s;
  } vec_t;

  vec_t vecs [12];

  initial begin
    vecs[0]  = '{8'd255, 1'b0, 12'h255, 12'h001};
    vecs[1]  = '{8'h80,  1'b1, 12'h128, 12'h128};
    vecs[2]  = '{8'h07,  1'b0, 12'h007, 12'h007};
    vecs[3]  = '{8'd200, 1'b0, 12'h200, 12'h056};
    vecs[4]  = '{8'd0,   1'b0, 12'h000, 12'h000};
    vecs[5]  = '{8'd100, 1'b1, 12'h100, 12'h100};
    vecs[6]  = '{8'd9,   1'b0, 12'h009, 12'h009};
    vecs[7]  = '{8'h9C,  1'b0, 12'h156, 12'h100};
    vecs[8]  = '{8'hF6,  1'b1, 12'h246, 12'h010};
    vecs[9]  = '{8'd99,  1'b0, 12'h099, 12'h099};
    vecs[10] = '{8'h81,  1'b0, 12'h129, 12'h127};
    vecs[11] = '{8'h7F,  1'b0, 12'h127, 12'h127};

    Reset = 1'b1; Value = 8'd0; Halt = 1'b0;
    tick();
    tick();
    Reset = 1'b0;
    repeat (40) tick();

    foreach (vecs[i]) begin
      Value = vecs[i].v;
      Halt  = vecs[i].h;
      wait_idle();
      check("tbl_bcd_u", 32'(u_bcd), 32'(vecs[i].bcd_u));
      check("tbl_bcd_s", 32'(s_bcd), 32'(vecs[i].bcd_s));
      repeat (20) tick();
    end

    // Halt overrides the minus sign on the status digit.
    Value = 8'h80; Halt = 1'b0;
    wait_idle();
    repeat (20) tick();
    wait_sign_digit();
    check("sign_dash", 32'(s_seg), 32'(7'b0111111));
    Halt = 1'b1;
    repeat (20) tick();
    wait_sign_digit();
    check("sign_halt", 32'(s_seg), 32'(7'b0001001));
    Halt = 1'b0;
    repeat (20) tick();
    wait_sign_digit();
    check("sign_dash_again", 32'(s_seg), 32'(7'b0111111));

    // A change during conversion is ignored, then captured after one idle cycle.
    Value = 8'd10;
    tick();
    check("b2b_capture", 32'(u_busy), 32'd1);
    Value = 8'd99;
    repeat (7) tick();
    check("b2b_busy7", 32'(u_busy), 32'd1);
    tick();
    check("b2b_done", 32'(u_busy), 32'd0);
    check("b2b_first", 32'(u_bcd), 32'(12'h010));
    tick();
    check("b2b_recapture", 32'(u_busy), 32'd1);
    repeat (8) tick();
    check("b2b_second", 32'(u_bcd), 32'(12'h099));
    check("b2b_idle", 32'(u_busy), 32'd0);

    // Reset during the fourth conversion cycle aborts; capture resumes after release.
    Value = 8'd200;
    tick();
    repeat (3) tick();
    Reset = 1'b1;
    tick();
    check("rst_busy", 32'(u_busy), 32'd0);
    check("rst_bcd", 32'(u_bcd), 32'(12'h000));
    Reset = 1'b0;
    tick();
    check("rst_recapture", 32'(u_busy), 32'd1);
    repeat (8) tick();
    check("rst_bcd_u", 32'(u_bcd), 32'(12'h200));
    check("rst_bcd_s", 32'(s_bcd), 32'(12'h056));

    for (int k = 0; k < 400; k++) begin
      Value = 8'($urandom);
      Halt  = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 40) == 0) begin
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
      end
      repeat ($urandom_range(1, 12)) tick();
    end
    repeat (30) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
